ext_in_buffer: RTL and testbench
================================

# ext_in_buffer

Input-port buffer for the accumulator datapath. It captures 16-bit words from an external producer through a valid/ready handshake and stores them in a small FIFO. On a control-unit read strobe it presents the oldest word, registered, on `ext_in`. `ext_in` drives the `in_1` leg of the B-operand 2:1 mux, opposite the data-memory word.

## Interface
- `DATA_WIDTH`, 16, word width; must match the B-mux width.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `ext_data` input DATA_WIDTH: word offered by the external producer.
- `ext_valid` input 1: `ext_data` is valid this cycle.
- `ext_ready` output 1: buffer accepts a word this cycle; equals `!ext_full`.
- `read_en` input 1: control unit pops one word (IN instruction).
- `ext_in` output DATA_WIDTH: registered popped word, feeds the B-mux `in_1`.
- `ext_empty` output 1: count == 0.
- `ext_full` output 1: count == DEPTH.
- `ext_count` output $clog2(DEPTH+1): number of stored words.
- `ext_underflow` output 1: sticky flag; present only with `EXT_IN_UNDERFLOW_EN`.

## Operation
- **Push.** Occurs when `ext_valid && ext_ready`. `ext_data` is written at `wr_ptr`, and `wr_ptr` advances modulo DEPTH.
- **Pop.** Occurs when `read_en && !ext_empty`. The word at `rd_ptr` is loaded into `ext_in`, and `rd_ptr` advances modulo DEPTH.
- **`ext_in` hold.** `ext_in` keeps its value until the next successful pop. It is never cleared by a push or by an idle cycle.
- **Count.** +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- **Flags.** `ext_empty`, `ext_full` and `ext_count` derive from the count register. They are registered state, not combinational from inputs.
- **Boundary conditions:**
  - Full: `ext_ready` = 0, so `ext_valid` is ignored. A simultaneous pop frees a slot, but the push is still refused that cycle because `ready` is based on the pre-edge state.
  - Empty: `read_en` does not pop and `ext_in` is unchanged. A simultaneous push is accepted, giving count 1.
  - Pointer wrap: pointers wrap from DEPTH−1 to 0 with no bubble. FIFO order is preserved across wrap.
- **Reset** (asserted at any time, including mid-transfer): pointers 0, count 0, `ext_in` 0, `ext_empty` 1, `ext_full` 0, `ext_ready` 1, `ext_underflow` 0. Any stored words are discarded.

## Timing
- Push-to-visible latency: a word pushed at edge N is poppable from edge N+1.
- Pop latency: `read_en` high in the cycle before edge N gives `ext_in` = head word after edge N. The control unit selects the B-mux `in_1` (`select_2x1` = 1) in the cycle after the strobe.
- `ext_ready` is valid in the same cycle as the state it reflects. The producer may hold `ext_valid` high across cycles; each accepting edge consumes exactly one word.
- Throughput: one push and one pop per cycle.

## Configuration
- **`EXT_IN_UNDERFLOW_EN` defined:**
  - Port `ext_underflow` exists. It is set on any edge where `read_en && ext_empty`.
  - It stays set until `reset`.
  - On an underflowing read, `ext_in` is loaded with 0 instead of holding its value.
- **`EXT_IN_UNDERFLOW_EN` undefined:**
  - Port `ext_underflow` is absent.
  - An underflowing read leaves `ext_in` unchanged.

## Structure
- **Package `ext_in_pkg`:**
  - `DATA_WIDTH_DEFAULT` = 16 and `DEPTH_DEFAULT` = 4.
  - typedef `word_t` (`logic [DATA_WIDTH_DEFAULT-1:0]`).
  - Function `ptr_w(depth)` returning $clog2(depth).
- **Sub-module `ext_in_mem`:** DEPTH×DATA_WIDTH storage with one write port and one asynchronous read port, with no reset on the array. Pointers, count, flags and the `ext_in` register stay in `ext_in_buffer`.

## Test plan
- **Reset:** assert `reset` mid-cycle with 2 words stored → immediately `ext_count` = 0, `ext_empty` = 1, `ext_in` = 16'h0000, `ext_ready` = 1.
- **FIFO order:** push 16'h0064 then 16'hFF49, then pulse `read_en` twice → `ext_in` = 16'h0064 after the first edge and 16'hFF49 after the second; `ext_empty` = 1 at the end.
- **Full:** fill 4 words 16'h0001–16'h0004 and hold `ext_valid` with 16'h0005 → `ext_ready` = 0 and `ext_count` = 4. Pop once → next edge accepts 16'h0005; five pops return 1,2,3,4,5.
- **Wrap and simultaneous:** cycle 10 words through the buffer with a simultaneous push and pop each cycle from count 1 → `ext_count` stays 1, and output order equals input order across pointer wrap.
- **Empty read:** `read_en` with the buffer empty and `ext_in` = 16'h0049 → macro off: `ext_in` stays 16'h0049. Macro on: `ext_in` = 16'h0000 and `ext_underflow` = 1 until `reset`.
- **Empty read with push:** `read_en` and a push of 16'h0064 in the same cycle from empty → push accepted, `ext_count` = 1, `ext_in` not updated; the next `read_en` yields 16'h0064.

Source files
------------

// File: rtl/ext_in_pkg.sv
// Shared defaults, word type and pointer-width helper for the external input buffer.
package ext_in_pkg;
  localparam int DATA_WIDTH_DEFAULT = 16;
  localparam int DEPTH_DEFAULT      = 4;

  typedef logic [DATA_WIDTH_DEFAULT-1:0] word_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/ext_in_mem.sv
// FIFO storage: one write port, one asynchronous read port, no reset on the array.
module ext_in_mem
  import ext_in_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int AW         = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk)
      if (wr_en && wr_addr == AW'(g)) mem[g] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/ext_in_buffer.sv
// External input-port FIFO feeding the B-mux in_1 leg with a registered popped word.
// Optional sticky underflow flag and zero-on-underflow behaviour under EXT_IN_UNDERFLOW_EN.
module ext_in_buffer
  import ext_in_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        ext_data,
  input  logic                         ext_valid,
  output logic                         ext_ready,
  input  logic                         read_en,
  output logic [DATA_WIDTH-1:0]        ext_in,
  output logic                         ext_empty,
  output logic                         ext_full,
`ifdef EXT_IN_UNDERFLOW_EN
  output logic                         ext_underflow,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   ext_count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] head;
  logic                  push, pop;

  // Ready comes from registered full, so a same-cycle pop never opens a slot.
  assign ext_ready = !ext_full;
  assign push      = ext_valid && ext_ready;
  assign pop       = read_en && !ext_empty;

  always_comb begin
    count_nxt = ext_count;
    case ({push, pop})
      2'b10:   count_nxt = ext_count + CW'(1);
      2'b01:   count_nxt = ext_count - CW'(1);
      default: count_nxt = ext_count;
    endcase
  end

  ext_in_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk    (clk),
    .wr_en  (push),
    .wr_addr(wr_ptr),
    .wr_data(ext_data),
    .rd_addr(rd_ptr),
    .rd_data(head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ext_count <= '0;
      ext_empty <= 1'b1;
      ext_full  <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      ext_count <= count_nxt;
      ext_empty <= (count_nxt == '0);
      ext_full  <= (count_nxt == CW'(DEPTH));
    end
  end

`ifdef EXT_IN_UNDERFLOW_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_in        <= '0;
      ext_underflow <= 1'b0;
    end else if (pop) begin
      ext_in <= head;
    end else if (read_en) begin
      ext_in        <= '0;
      ext_underflow <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    ext_in <= '0;
    else if (pop) ext_in <= head;
  end
`endif
endmodule

// File: tb/tb_ext_in_buffer.sv
// Directed bench for ext_in_buffer with a queue-based reference model checked every cycle.
module tb_ext_in_buffer;
  localparam int DW = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] ext_data = '0;
  logic          ext_valid = 1'b0;
  logic          read_en = 1'b0;
  logic          ext_ready, ext_empty, ext_full;
  logic [DW-1:0] ext_in;
  logic [CW-1:0] ext_count;
`ifdef EXT_IN_UNDERFLOW_EN
  logic          ext_underflow;
  localparam bit UF = 1'b1;
`else
  localparam bit UF = 1'b0;
`endif

  ext_in_buffer #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .ext_data (ext_data),
    .ext_valid(ext_valid),
    .ext_ready(ext_ready),
    .read_en  (read_en),
    .ext_in   (ext_in),
    .ext_empty(ext_empty),
    .ext_full (ext_full),
`ifdef EXT_IN_UNDERFLOW_EN
    .ext_underflow(ext_underflow),
`endif
    .ext_count(ext_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_in = '0;
  bit            m_uf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(ext_count), 32'(q.size()));
    chk("empty", 32'(ext_empty), 32'(q.size() == 0));
    chk("full",  32'(ext_full),  32'(q.size() == D));
    chk("ready", 32'(ext_ready), 32'(q.size() != D));
    chk("ext_in", 32'(ext_in), 32'(m_in));
`ifdef EXT_IN_UNDERFLOW_EN
    chk("underflow", 32'(ext_underflow), 32'(m_uf));
`endif
  endtask

  // One clock: drive inputs, predict from pre-edge model state, compare after the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic rd);
    bit push, pop;
    ext_valid = v;
    ext_data  = d;
    read_en   = rd;
    push = v && (q.size() < D);
    pop  = rd && (q.size() > 0);
    @(posedge clk);
    if (pop) m_in = q.pop_front();
    else if (rd && UF) begin
      m_in = '0;
      m_uf = 1'b1;
    end
    if (push) q.push_back(d);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_in = '0;
    m_uf = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    model_reset();
    check_all();
    chk("rst_ready_lit", 32'(ext_ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // FIFO order
    step(1'b1, 16'h0064, 1'b0);
    step(1'b1, 16'hFF49, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("order1_lit", 32'(ext_in), 32'h0064);
    step(1'b0, '0, 1'b1);
    chk("order2_lit", 32'(ext_in), 32'hFF49);
    chk("order_empty_lit", 32'(ext_empty), 32'h1);

    // Full
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 16'h0005, 1'b0);
    chk("full_ready_lit", 32'(ext_ready), 32'h0);
    chk("full_count_lit", 32'(ext_count), 32'h4);
    step(1'b1, 16'h0005, 1'b1);
    chk("full_pop_lit", 32'(ext_in), 32'h0001);
    chk("full_refuse_lit", 32'(ext_count), 32'h3);
    step(1'b1, 16'h0005, 1'b0);
    chk("full_accept_lit", 32'(ext_count), 32'h4);
    for (int i = 2; i <= 5; i++) begin
      step(1'b0, '0, 1'b1);
      chk("full_drain_lit", 32'(ext_in), 32'(i));
    end

    // Wrap with simultaneous push/pop at count 1
    step(1'b1, 16'h0100, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(16'h0101 + i), 1'b1);
      chk("wrap_data_lit", 32'(ext_in), 32'(16'h0100 + i));
      chk("wrap_count_lit", 32'(ext_count), 32'h1);
    end
    step(1'b0, '0, 1'b1);

    // Empty read
    step(1'b1, 16'h0049, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("pre_empty_lit", 32'(ext_in), 32'h0049);
    step(1'b0, '0, 1'b1);
    chk("empty_read_lit", 32'(ext_in), UF ? 32'h0 : 32'h0049);

    // Empty read with same-cycle push
    step(1'b1, 16'h0064, 1'b1);
    chk("er_push_count_lit", 32'(ext_count), 32'h1);
    chk("er_push_hold_lit", 32'(ext_in), UF ? 32'h0 : 32'h0049);
    step(1'b0, '0, 1'b1);
    chk("er_push_pop_lit", 32'(ext_in), 32'h0064);

    // Reset mid-cycle with 2 words stored
    step(1'b1, 16'h0AAA, 1'b0);
    step(1'b1, 16'h0BBB, 1'b0);
    ext_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_mid_count_lit", 32'(ext_count), 32'h0);
    chk("rst_mid_in_lit", 32'(ext_in), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 16'h1234, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("post_rst_lit", 32'(ext_in), 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
